key_search_arbiter: RTL and testbench

KEY_SEARCH_ARBITER -- requirements
Module: key_search_arbiter

---
 rtl/key_search_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_key_search_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_search_arbiter.sv
// key_search_arbiter: launches a group of parallel key-search cores, freezes them
// on the first success (lowest core index wins) or once every core has reported
// key-space exhaustion, and latches the winning key and core index.
// Optional build macro KEY_SEARCH_TIMER_EN adds a saturating 32-bit elapsed_cycles
// counter of the cycles spent in RUN.
module key_search_arbiter #(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CORES-1:0]      core_success,
  input  logic [NUM_CORES-1:0]      core_failure,
  input  logic [24*NUM_CORES-1:0]   core_key,
  output logic                      core_clear,
  output logic                      stop,
  output logic                      busy,
  output logic                      found,
  output logic                      exhausted,
  output logic [23:0]               found_key,
  output logic [2:0]                found_core
`ifdef KEY_SEARCH_TIMER_EN
  ,
  output logic [31:0]               elapsed_cycles
`endif
);

  localparam int unsigned KEY_W = 24;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned TMR_W = 32;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_FOUND     = 3'd3;
  localparam logic [2:0] S_EXHAUSTED = 3'd4;

  logic [2:0]           r_state;
  logic [NUM_CORES-1:0] r_fail_mask;
  logic                 r_core_clear;
  logic                 r_stop;
  logic                 r_busy;
  logic                 r_found;
  logic                 r_exhausted;
  logic [KEY_W-1:0]     r_found_key;
  logic [IDX_W-1:0]     r_found_core;

  logic [2:0]           w_state_nxt;
  logic [NUM_CORES-1:0] w_fail_mask_nxt;
  logic                 w_found_nxt;
  logic                 w_exhausted_nxt;
  logic [KEY_W-1:0]     w_found_key_nxt;
  logic [IDX_W-1:0]     w_found_core_nxt;

  logic                 w_any_success;
  logic [IDX_W-1:0]     w_win_idx;
  logic [KEY_W-1:0]     w_win_key;
  logic [NUM_CORES-1:0] w_fail_mask_upd;
  logic                 w_all_failed;

`ifdef KEY_SEARCH_TIMER_EN
  logic [TMR_W-1:0]     r_elapsed;
  logic [TMR_W-1:0]     w_elapsed_nxt;
`endif

  // Priority pick of the lowest-index successful core and its key
  always_comb begin
    w_any_success = |core_success;
    w_win_idx     = '0;
    w_win_key     = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_success[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_key = core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Sticky fail mask including this cycle's failures
  always_comb begin
    w_fail_mask_upd = r_fail_mask | core_failure;
    w_all_failed    = &w_fail_mask_upd;
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_fail_mask_nxt  = r_fail_mask;
    w_found_nxt      = r_found;
    w_exhausted_nxt  = r_exhausted;
    w_found_key_nxt  = r_found_key;
    w_found_core_nxt = r_found_core;
`ifdef KEY_SEARCH_TIMER_EN
    w_elapsed_nxt    = r_elapsed;
`endif
    case (r_state)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          // Results are wiped on entry so they already read zero during CLEAR
          w_state_nxt      = S_CLEAR;
          w_fail_mask_nxt  = '0;
          w_found_nxt      = 1'b0;
          w_exhausted_nxt  = 1'b0;
          w_found_key_nxt  = '0;
          w_found_core_nxt = '0;
`ifdef KEY_SEARCH_TIMER_EN
          w_elapsed_nxt    = '0;
`endif
        end
      end
      S_CLEAR: begin
        w_state_nxt     = S_RUN;
        w_fail_mask_nxt = '0;
      end
      S_RUN: begin
        w_fail_mask_nxt = w_fail_mask_upd;
`ifdef KEY_SEARCH_TIMER_EN
        if (r_elapsed != {TMR_W{1'b1}}) begin
          w_elapsed_nxt = r_elapsed + TMR_W'(1);
        end
`endif
        // Success outranks a simultaneous final failure
        if (w_any_success) begin
          w_state_nxt      = S_FOUND;
          w_found_nxt      = 1'b1;
          w_found_key_nxt  = w_win_key;
          w_found_core_nxt = w_win_idx;
        end else if (w_all_failed) begin
          w_state_nxt     = S_EXHAUSTED;
          w_exhausted_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; control outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fail_mask  <= '0;
      r_core_clear <= 1'b0;
      r_stop       <= 1'b1;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_exhausted  <= 1'b0;
      r_found_key  <= '0;
      r_found_core <= '0;
`ifdef KEY_SEARCH_TIMER_EN
      r_elapsed    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_fail_mask  <= w_fail_mask_nxt;
      r_core_clear <= (w_state_nxt == S_CLEAR);
      r_stop       <= (w_state_nxt != S_RUN);
      r_busy       <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_RUN);
      r_found      <= w_found_nxt;
      r_exhausted  <= w_exhausted_nxt;
      r_found_key  <= w_found_key_nxt;
      r_found_core <= w_found_core_nxt;
`ifdef KEY_SEARCH_TIMER_EN
      r_elapsed    <= w_elapsed_nxt;
`endif
    end
  end

  assign core_clear = r_core_clear;
  assign stop       = r_stop;
  assign busy       = r_busy;
  assign found      = r_found;
  assign exhausted  = r_exhausted;
  assign found_key  = r_found_key;
  assign found_core = r_found_core;
`ifdef KEY_SEARCH_TIMER_EN
  assign elapsed_cycles = r_elapsed;
`endif

endmodule

// File: tb/tb_key_search_arbiter.sv
// Bench for key_search_arbiter: directed scenarios followed by random traffic,
// all checked against a phase-level behavioural model of the arbiter.
module tb_key_search_arbiter;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NC-1:0] core_success;
  logic [NC-1:0] core_failure;
  logic [24*NC-1:0] core_key;
  logic          core_clear, stop, busy, found, exhausted;
  logic [23:0]   found_key;
  logic [2:0]    found_core;
`ifdef KEY_SEARCH_TIMER_EN
  logic [31:0]   elapsed_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // model: phase 0=idle 1=clear 2=run 3=found 4=exhausted
  int          m_phase;
  int          m_failed [NC];
  logic        m_found, m_exh;
  logic [23:0] m_key;
  int          m_core;
  longint      m_timer;

  key_search_arbiter #(.NUM_CORES(NC)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .core_success (core_success),
    .core_failure (core_failure),
    .core_key     (core_key),
    .core_clear   (core_clear),
    .stop         (stop),
    .busy         (busy),
    .found        (found),
    .exhausted    (exhausted),
    .found_key    (found_key),
    .found_core   (found_core)
`ifdef KEY_SEARCH_TIMER_EN
    ,
    .elapsed_cycles (elapsed_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge with the currently driven inputs
  task automatic model_edge();
    int nfailed;
    if (reset) begin
      m_phase = 0; m_found = 0; m_exh = 0; m_key = 0; m_core = 0; m_timer = 0;
      for (int i = 0; i < NC; i++) m_failed[i] = 0;
    end else if (m_phase == 0 || m_phase == 3 || m_phase == 4) begin
      if (start) begin
        m_phase = 1; m_found = 0; m_exh = 0; m_key = 0; m_core = 0; m_timer = 0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      for (int i = 0; i < NC; i++) m_failed[i] = 0;
    end else begin
      if (m_timer < 64'hFFFF_FFFF) m_timer = m_timer + 1;
      for (int i = 0; i < NC; i++) if (core_failure[i]) m_failed[i] = 1;
      nfailed = 0;
      for (int i = 0; i < NC; i++) nfailed += m_failed[i];
      if (core_success != 0) begin
        for (int i = NC - 1; i >= 0; i--) if (core_success[i]) m_core = i;
        m_key   = core_key[m_core*24 +: 24];
        m_found = 1;
        m_phase = 3;
      end else if (nfailed == NC) begin
        m_exh   = 1;
        m_phase = 4;
      end
    end
  endtask

  task automatic check_all();
    chk("core_clear", 32'(core_clear), 32'(m_phase == 1));
    chk("busy",       32'(busy),       32'(m_phase == 1 || m_phase == 2));
    chk("stop",       32'(stop),       32'(m_phase != 2));
    chk("found",      32'(found),      32'(m_found));
    chk("exhausted",  32'(exhausted),  32'(m_exh));
    chk("found_key",  32'(found_key),  32'(m_key));
    chk("found_core", 32'(found_core), 32'(m_core));
    chk("not_both",   32'(found & exhausted), 32'd0);
`ifdef KEY_SEARCH_TIMER_EN
    chk("elapsed",    elapsed_cycles,  32'(m_timer));
`endif
  endtask

  task automatic step(input logic rst, input logic st, input logic [NC-1:0] succ,
                      input logic [NC-1:0] fail);
    reset = rst; start = st; core_success = succ; core_failure = fail;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; core_success = '0; core_failure = '0;
    core_key = {24'hDDDDDD, 24'h001234, 24'hBBBBBB, 24'hAAAAAA};
    m_phase = 0; m_found = 0; m_exh = 0; m_key = 0; m_core = 0; m_timer = 0;
    for (int i = 0; i < NC; i++) m_failed[i] = 0;

    // reset, with start and core inputs also high to show reset priority
    step(1, 1, 4'b1111, 4'b1111);
    step(1, 0, 0, 0);
    chk("rst_stop", 32'(stop), 32'd1);

    // launch: CLEAR in cycle 1, RUN from cycle 2
    step(0, 1, 0, 0);
    chk("clear_pulse", 32'(core_clear), 32'd1);
    step(0, 0, 0, 0);
    chk("run_stop", 32'(stop), 32'd0);
    step(0, 1, 0, 0);  // start ignored in RUN

    // core 2 wins with key 001234
    step(0, 0, 4'b0100, 0);
    chk("k2_key",  32'(found_key),  32'h001234);
    chk("k2_core", 32'(found_core), 32'd2);
    step(0, 0, 0, 0);  // held

    // simultaneous successes: lowest index wins
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    core_key[47:24] = 24'h5A5A5A;
    step(0, 0, 4'b1010, 0);
    chk("tie_core", 32'(found_core), 32'd1);
    chk("tie_key",  32'(found_key),  32'h5A5A5A);

    // failures at separate cycles exhaust the search
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0001);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b1000);
    step(0, 0, 0, 0);
    chk("not_yet_exh", 32'(exhausted), 32'd0);
    step(0, 0, 0, 4'b0010);
    chk("exh", 32'(exhausted), 32'd1);
    step(0, 0, 0, 0);

    // success and final failure together: success wins, timer freezes
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0011);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 4'b0001, 4'b1000);
    chk("race_exh", 32'(exhausted), 32'd0);
    chk("race_core", 32'(found_core), 32'd0);
    step(0, 0, 4'b0010, 4'b1111);
    step(0, 0, 0, 0);

    // success from an already-failed core is accepted
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 4'b0100, 0);
    chk("failed_core_wins", 32'(found_core), 32'd2);

    // reset mid-RUN then restart with an empty fail mask
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0011);
    step(1, 0, 4'b0001, 4'b1100);
    chk("abort_no_clear", 32'(core_clear), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b1100);
    chk("mask_emptied", 32'(exhausted), 32'd0);
    step(0, 0, 0, 4'b0011);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic r, s;
      logic [NC-1:0] sc, fl;
      core_key = {$urandom, $urandom, $urandom};
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 3) == 0);
      sc = ($urandom_range(0, 9) == 0) ? NC'($urandom) : '0;
      fl = '0;
      for (int i = 0; i < NC; i++) fl[i] = ($urandom_range(0, 5) == 0);
      step(r, s, sc, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
